wb_master_arbiter: RTL

//  N-to-1 pipelined Wishbone (B4) arbiter. It merges the core's master ports (instruction fetch, LSU, and later debug/DMA) onto one system bus port.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 55 +++++
 rtl/wb_master_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types for the Wishbone master arbiter slice.
//   arb_mode_e  : arbitration policy selected at elaboration time
//   arb_state_e : arbiter FSM states
// -----------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,  // lowest requesting index wins
    ARB_RR    = 1'b1   // round-robin starting at the rotating pointer
  } arb_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no grant, waiting for any CYC
    BUSY  = 2'd1,  // grant locked to one master, requests forwarded
    DRAIN = 2'd2   // master left early, absorbing outstanding responses
  } arb_state_e;

endpackage : wb_pkg

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational N-way priority picker with a rotating base. The first request
// at or above base_i (wrapping modulo N) wins. Tie base_i to zero for plain
// fixed priority.
// Ports:
//   req_i   in  N    request vector
//   base_i  in  IW   index that has highest priority
//   gnt_o   out N    one-hot winner (all zero when no request)
//   idx_o   out IW   binary index of the winner
//   valid_o out 1    at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [IW-1:0]  off_s;
  logic [IW:0]    sum_s;

  // Rotate requests so base_i lands at bit 0, find the first set bit, then
  // translate that offset back to an absolute master index.
  always_comb begin
    dbl_s   = {req_i, req_i};
    rot_s   = N'(dbl_s >> base_i);
    valid_o = 1'b0;
    off_s   = {IW{1'b0}};
    for (int i = 0; i < int'(N); i++) begin
      if (!valid_o && rot_s[i]) begin
        valid_o = 1'b1;
        off_s   = IW'(i);
      end else begin
        valid_o = valid_o;
      end
    end
    sum_s = {1'b0, base_i} + {1'b0, off_s};
    if (sum_s >= (IW+1)'(N)) begin
      idx_o = IW'(sum_s - (IW+1)'(N));
    end else begin
      idx_o = IW'(sum_s);
    end
    for (int j = 0; j < int'(N); j++) begin
      gnt_o[j] = valid_o & (idx_o == IW'(j));
    end
  end

endmodule : rr_picker

// File: rtl/wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter
// N-to-1 pipelined Wishbone B4 arbiter. A grant is taken in IDLE (one cycle of
// arbitration, no strobe issued) and held for the whole CYC of the winner.
// Accepted-but-unanswered requests are counted and bounded by MAX_OUTST. If the
// winner drops CYC with responses pending, the arbiter keeps the slave cycle
// open (DRAIN) and swallows those responses before releasing.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i       per-master controls (N bits)
//   m_adr_i/m_dat_i/m_sel_i      per-master address/data/select, master k at k*W
//   m_dat_o                      slave read data broadcast to all masters
//   m_ack_o/m_err_o              responses, only to the granted master
//   m_stall_o                    stall, always 1 for non-granted masters
//   s_cyc_o/s_stb_o/s_we_o       slave-side controls
//   s_adr_o/s_dat_o/s_sel_o      slave-side address/data/select
//   s_dat_i/s_ack_i/s_err_i/s_stall_i  slave responses
//   grant_o                      registered one-hot grant (zero when idle)
//   proto_err_o                  sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module wb_master_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter arb_mode_e   ARB_MODE  = ARB_RR,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_MASTERS-1:0]      m_cyc_i,
  input  logic [N_MASTERS-1:0]      m_stb_i,
  input  logic [N_MASTERS-1:0]      m_we_i,
  input  logic [N_MASTERS*AW-1:0]   m_adr_i,
  input  logic [N_MASTERS*DW-1:0]   m_dat_i,
  input  logic [N_MASTERS*DW/8-1:0] m_sel_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [N_MASTERS-1:0]      m_ack_o,
  output logic [N_MASTERS-1:0]      m_err_o,
  output logic [N_MASTERS-1:0]      m_stall_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [DW/8-1:0]           s_sel_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_stall_i,
  output logic [N_MASTERS-1:0]      grant_o,
  output logic                      proto_err_o
);

  localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW = DW / 8;

  arb_state_e               state_q, state_d;
  logic [N_MASTERS-1:0]     grant_q, grant_d;
  logic [IW-1:0]            gidx_q, gidx_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     proto_err_q;

  logic [IW-1:0]            pick_base_s;
  logic [N_MASTERS-1:0]     pick_gnt_s;
  logic [IW-1:0]            pick_idx_s;
  logic                     pick_valid_s;
  logic [IW-1:0]            next_ptr_s;

  logic                     cyc_g_s, stb_g_s, we_g_s;
  logic [AW-1:0]            adr_g_s;
  logic [DW-1:0]            dat_g_s;
  logic [SW-1:0]            sel_g_s;
  logic                     sel_k_s;

  logic                     cnt_nz_s, full_s, resp_s, inc_s, dec_s, proto_set_s;

  // Fixed priority simply never rotates the picker base.
  assign pick_base_s = (ARB_MODE == ARB_RR) ? ptr_q : {IW{1'b0}};
  assign next_ptr_s  = (gidx_q == IW'(N_MASTERS - 1)) ? {IW{1'b0}} : (gidx_q + IW'(1));

  rr_picker #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_picker (
    .req_i   (m_cyc_i),
    .base_i  (pick_base_s),
    .gnt_o   (pick_gnt_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  assign cnt_nz_s    = (cnt_q != {CW{1'b0}});
  assign full_s      = (cnt_q == CW'(MAX_OUTST));
  assign resp_s      = s_ack_i | s_err_i;
  assign proto_set_s = resp_s & ~cnt_nz_s;

  assign m_dat_o     = s_dat_i;
  assign grant_o     = grant_q;
  assign proto_err_o = proto_err_q;

  // AND-OR mux selecting the granted master's request signals.
  always_comb begin
    cyc_g_s = 1'b0;
    stb_g_s = 1'b0;
    we_g_s  = 1'b0;
    adr_g_s = {AW{1'b0}};
    dat_g_s = {DW{1'b0}};
    sel_g_s = {SW{1'b0}};
    sel_k_s = 1'b0;
    for (int k = 0; k < int'(N_MASTERS); k++) begin
      sel_k_s = (gidx_q == IW'(k));
      cyc_g_s = cyc_g_s | (sel_k_s & m_cyc_i[k]);
      stb_g_s = stb_g_s | (sel_k_s & m_stb_i[k]);
      we_g_s  = we_g_s  | (sel_k_s & m_we_i[k]);
      adr_g_s = adr_g_s | ({AW{sel_k_s}} & m_adr_i[k*AW +: AW]);
      dat_g_s = dat_g_s | ({DW{sel_k_s}} & m_dat_i[k*DW +: DW]);
      sel_g_s = sel_g_s | ({SW{sel_k_s}} & m_sel_i[k*SW +: SW]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, grant capture and pointer advance on release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d = BUSY;
          grant_d = pick_gnt_s;
          gidx_d  = pick_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!cyc_g_s) begin
          if (!cnt_nz_s) begin
            state_d = IDLE;
            grant_d = {N_MASTERS{1'b0}};
            ptr_d   = next_ptr_s;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = BUSY;
        end
      end
      DRAIN: begin
        if (!cnt_nz_s) begin
          state_d = IDLE;
          grant_d = {N_MASTERS{1'b0}};
          ptr_d   = next_ptr_s;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {N_MASTERS{1'b0}};
      end
    endcase
  end

  // FSM outputs: slave-side request and master-side response routing.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = {AW{1'b0}};
    s_dat_o   = {DW{1'b0}};
    s_sel_o   = {SW{1'b0}};
    m_ack_o   = {N_MASTERS{1'b0}};
    m_err_o   = {N_MASTERS{1'b0}};
    m_stall_o = {N_MASTERS{1'b1}};
    case (state_q)
      IDLE: begin
        s_cyc_o = 1'b0;
      end
      BUSY: begin
        // Keep the slave cycle open in the cycle CYC drops with work pending,
        // so it never glitches low on the way into DRAIN.
        s_cyc_o   = cyc_g_s | cnt_nz_s;
        s_stb_o   = cyc_g_s & stb_g_s & ~full_s;
        s_we_o    = we_g_s;
        s_adr_o   = adr_g_s;
        s_dat_o   = dat_g_s;
        s_sel_o   = sel_g_s;
        m_stall_o = ~grant_q | {N_MASTERS{s_stall_i | full_s}};
        m_ack_o   = grant_q & {N_MASTERS{s_ack_i & cnt_nz_s}};
        m_err_o   = grant_q & {N_MASTERS{s_err_i & cnt_nz_s}};
      end
      DRAIN: begin
        s_cyc_o = 1'b1;
        s_we_o  = we_g_s;
        s_adr_o = adr_g_s;
        s_dat_o = dat_g_s;
        s_sel_o = sel_g_s;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  // Outstanding counter; inc and dec together cancel, full blocks further strobes.
  always_comb begin
    inc_s = s_stb_o & ~s_stall_i;
    dec_s = resp_s & cnt_nz_s;
    if (inc_s && !dec_s) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec_s && !inc_s) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Grant, pointer, counter and sticky protocol-error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q     <= {N_MASTERS{1'b0}};
      gidx_q      <= {IW{1'b0}};
      ptr_q       <= {IW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      proto_err_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_q | proto_set_s;
    end
  end

endmodule : wb_master_arbiter
